// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO write-side frame controller.
package fifo_pkg;

  localparam int unsigned DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND_LO = 2'd1,
    ST_SEND_HI = 2'd2
  } wr_state_e;

endpackage

// File: rtl/wr_frame_ctrl.sv
// Write-side frame controller: splits a one- or two-word request into
// FIFO write strobes, stalling on wfull and counting words written.
module wr_frame_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic [2*DATA_W-1:0]   in_data,
  input  logic                  in_wide,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  wfull,
  output logic                  winc,
  output logic [DATA_W-1:0]     wdata,
  output logic                  busy,
  output logic [7:0]            wr_cnt
);

  wr_state_e             state_q, state_d;
  logic [2*DATA_W-1:0]   hold_data_q;
  logic                  hold_wide_q;
  logic                  rdy_en_q;
  logic [7:0]            wr_cnt_q;
  logic                  accept;

  // rdy_en_q keeps in_ready low during reset and until the first edge after release.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q     <= ST_IDLE;
      hold_data_q <= '0;
      hold_wide_q <= 1'b0;
      rdy_en_q    <= 1'b0;
      wr_cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rdy_en_q <= 1'b1;
      if (accept) begin
        hold_data_q <= in_data;
        hold_wide_q <= in_wide;
      end
      if (winc) begin
        wr_cnt_q <= wr_cnt_q + 8'd1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    accept   = 1'b0;
    winc     = 1'b0;
    wdata    = '0;
    unique case (state_q)
      ST_IDLE: begin
        in_ready = rdy_en_q;
        accept   = rdy_en_q && in_valid;
        if (accept) begin
          state_d = ST_SEND_LO;
        end
      end
      ST_SEND_LO: begin
        winc  = !wfull;
        wdata = hold_data_q[DATA_W-1:0];
        if (!wfull) begin
          state_d = hold_wide_q ? ST_SEND_HI : ST_IDLE;
        end
      end
      ST_SEND_HI: begin
        winc  = !wfull;
        wdata = hold_data_q[2*DATA_W-1:DATA_W];
        if (!wfull) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy   = (state_q != ST_IDLE);
  assign wr_cnt = wr_cnt_q;

endmodule

// File: tb/tb_wr_frame_ctrl.sv
// Self-checking bench for wr_frame_ctrl: queue-based word model plus directed literal checks.
module tb_wr_frame_ctrl;

  localparam int DW = 8;

  logic            wclk;
  logic            wrst_n;
  logic [2*DW-1:0] in_data;
  logic            in_wide;
  logic            in_valid;
  logic            in_ready;
  logic            wfull;
  logic            winc;
  logic [DW-1:0]   wdata;
  logic            busy;
  logic [7:0]      wr_cnt;

  int checks = 0;
  int errors = 0;

  wr_frame_ctrl #(.DATA_W(DW)) dut (
    .wclk     (wclk),
    .wrst_n   (wrst_n),
    .in_data  (in_data),
    .in_wide  (in_wide),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .wfull    (wfull),
    .winc     (winc),
    .wdata    (wdata),
    .busy     (busy),
    .wr_cnt   (wr_cnt)
  );

  initial begin
    wclk = 1'b0;
    forever #5 wclk = ~wclk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: words still owed to the FIFO for the current frame, in order.
  logic [DW-1:0] m_q[$];
  bit            m_rdy = 1'b0;
  logic [7:0]    m_cnt = 8'd0;

  always @(posedge wclk) begin
    bit was_rdy;
    if (!wrst_n) begin
      m_q.delete();
      m_rdy = 1'b0;
      m_cnt = 8'd0;
    end else begin
      was_rdy = m_rdy;
      if (m_q.size() != 0) begin
        if (!wfull) begin
          void'(m_q.pop_front());
          m_cnt = m_cnt + 8'd1;
        end
      end else if (was_rdy && in_valid) begin
        m_q.push_back(in_data[DW-1:0]);
        if (in_wide) m_q.push_back(in_data[2*DW-1:DW]);
      end
      m_rdy = 1'b1;
    end
  end

  always @(negedge wclk) begin
    logic          e_busy;
    logic [DW-1:0] e_wdata;
    if (!wrst_n) begin
      m_q.delete();
      m_rdy = 1'b0;
      m_cnt = 8'd0;
    end
    e_busy  = (m_q.size() != 0);
    e_wdata = e_busy ? m_q[0] : '0;
    chk("cyc_in_ready", 32'(in_ready), 32'(m_rdy && !e_busy && wrst_n));
    chk("cyc_busy",     32'(busy),     32'(e_busy));
    chk("cyc_winc",     32'(winc),     32'(e_busy && !wfull));
    chk("cyc_wdata",    32'(wdata),    32'(e_wdata));
    chk("cyc_wr_cnt",   32'(wr_cnt),   32'(m_cnt));
  end

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  task automatic do_reset();
    wrst_n = 1'b0;
    in_valid = 1'b0;
    wfull = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_wr_cnt",   32'(wr_cnt),   32'd0);
    tick();
    tick();
    wrst_n = 1'b1;
    #1;
    chk("rst_rel_ready_low", 32'(in_ready), 32'd0);
    tick();
    chk("rst_rel_ready_high", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int n_winc;
    int n_rdy;
    wrst_n   = 1'b0;
    in_data  = '0;
    in_wide  = 1'b0;
    in_valid = 1'b0;
    wfull    = 1'b0;
    tick();

    // narrow 0x00A5
    do_reset();
    in_data = 16'h00A5; in_wide = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; in_data = 16'hFFFF;
    #1;
    chk("nar_winc",  32'(winc),  32'd1);
    chk("nar_wdata", 32'(wdata), 32'hA5);
    tick();
    chk("nar_winc_off", 32'(winc),     32'd0);
    chk("nar_cnt",      32'(wr_cnt),   32'd1);
    chk("nar_ready",    32'(in_ready), 32'd1);

    // wide 0x3C5A
    do_reset();
    in_data = 16'h3C5A; in_wide = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; in_data = 16'h0000;
    #1;
    chk("wide_lo_winc",  32'(winc),  32'd1);
    chk("wide_lo_wdata", 32'(wdata), 32'h5A);
    tick();
    chk("wide_hi_winc",  32'(winc),  32'd1);
    chk("wide_hi_wdata", 32'(wdata), 32'h3C);
    tick();
    chk("wide_ready", 32'(in_ready), 32'd1);
    chk("wide_cnt",   32'(wr_cnt),   32'd2);

    // wide 0x1234 stalled 5 cycles before the high word
    do_reset();
    in_data = 16'h1234; in_wide = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    #1;
    chk("stall_lo_wdata", 32'(wdata), 32'h34);
    tick();
    wfull = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_winc",  32'(winc),  32'd0);
      chk("stall_wdata", 32'(wdata), 32'h12);
      tick();
    end
    wfull = 1'b0;
    #1;
    chk("stall_release_winc",  32'(winc),  32'd1);
    chk("stall_release_wdata", 32'(wdata), 32'h12);
    tick();
    chk("stall_done_busy", 32'(busy),   32'd0);
    chk("stall_done_cnt",  32'(wr_cnt), 32'd2);

    // reset during the high word of 0xBEEF
    do_reset();
    in_data = 16'hBEEF; in_wide = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("abort_hi_wdata", 32'(wdata), 32'hBE);
    wrst_n = 1'b0;
    #1;
    chk("abort_winc",  32'(winc),   32'd0);
    chk("abort_wdata", 32'(wdata),  32'd0);
    chk("abort_cnt",   32'(wr_cnt), 32'd0);
    tick();
    wrst_n = 1'b1;
    n_winc = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (winc) n_winc++;
    end
    chk("abort_no_write", 32'(n_winc), 32'd0);

    // 256 back-to-back narrow requests with in_data churning every cycle
    do_reset();
    in_wide = 1'b0; in_valid = 1'b1;
    n_winc = 0;
    n_rdy = 0;
    for (int i = 0; i < 512; i++) begin
      in_data = 16'($urandom);
      #1;
      if (winc) n_winc++;
      if (in_ready) n_rdy++;
      tick();
    end
    in_valid = 1'b0;
    #1;
    chk("b2b_winc_count",  32'(n_winc), 32'd256);
    chk("b2b_accept_count", 32'(n_rdy), 32'd256);
    chk("b2b_cnt_wrap",    32'(wr_cnt), 32'd0);
    chk("b2b_idle",        32'(busy),   32'd0);

    // randomized traffic with backpressure and occasional reset
    for (int c = 0; c < 4000; c++) begin
      wrst_n   = ($urandom_range(0, 199) != 0);
      in_valid = ($urandom_range(0, 9) < 7);
      in_wide  = 1'($urandom);
      in_data  = 16'($urandom);
      wfull    = ($urandom_range(0, 9) < 3);
      tick();
    end
    wrst_n = 1'b1;
    in_valid = 1'b0;
    wfull = 1'b0;
    tick();
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
